// File: rtl/controlador_recepcao_paridade_if.sv
// Serial receive line, counter clear and delivered-byte outputs of the parity receiver.
interface controlador_recepcao_paridade_if #(
  parameter int unsigned LARGURA_CONTADOR = 16
);
  logic                        rx;
  logic                        limpar_contador;
  logic [7:0]                  dados_saida;
  logic                        erro_paridade;
  logic                        erro_quadro;
  logic                        valido;
  logic                        ocupado;
  logic [LARGURA_CONTADOR-1:0] contador_erros;

  modport master (
    output rx, limpar_contador,
    input  dados_saida, erro_paridade, erro_quadro, valido, ocupado, contador_erros
  );

  modport slave (
    input  rx, limpar_contador,
    output dados_saida, erro_paridade, erro_quadro, valido, ocupado, contador_erros
  );
endinterface

// File: rtl/controlador_recepcao_paridade.sv
// Serial frame receiver (start, 8 data LSB first, parity, stop) with mid-bit sampling,
// parity/framing flags and a saturating bad-frame counter.
module controlador_recepcao_paridade #(
  parameter int unsigned CICLOS_POR_BIT   = 16,
  parameter bit          PARIDADE_IMPAR   = 1'b1,
  parameter int unsigned LARGURA_CONTADOR = 16
) (
  input logic clk,
  input logic rst_n,
  controlador_recepcao_paridade_if.slave bus
);

  localparam int unsigned LT = $clog2(CICLOS_POR_BIT);
  localparam logic [LT-1:0] MEIO_BIT = LT'(CICLOS_POR_BIT / 2 - 1);
  localparam logic [LT-1:0] FIM_BIT  = LT'(CICLOS_POR_BIT - 1);

  typedef enum logic [2:0] {
    OCIOSO,
    INICIO,
    DADOS,
    PARIDADE,
    PARADA,
    ENTREGA
  } estado_t;

  estado_t estado;
  estado_t proximo;

  logic                        rx_meta;
  logic                        rx_s;
  logic [LT-1:0]               timer;
  logic [2:0]                  indice;
  logic [7:0]                  deslocador;
  logic                        bit_paridade;
  logic                        bit_parada;

  logic                        amostra;
  logic                        entrega;
  logic                        ocupado;
  logic                        erro_par_calc;
  logic                        erro_quadro_calc;

  logic [7:0]                  dados_q;
  logic                        erro_par_q;
  logic                        erro_quadro_q;
  logic                        valido_q;
  logic [LARGURA_CONTADOR-1:0] contador_q;

  // Two-flop synchronizer; preset to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado <= OCIOSO;
    end else begin
      estado <= proximo;
    end
  end

  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO: begin
        if (!rx_s) proximo = INICIO;
      end
      INICIO: begin
        if (amostra) proximo = rx_s ? OCIOSO : DADOS;
      end
      DADOS: begin
        if (amostra && (indice == 3'd7)) proximo = PARIDADE;
      end
      PARIDADE: begin
        if (amostra) proximo = PARADA;
      end
      PARADA: begin
        if (amostra) proximo = ENTREGA;
      end
      ENTREGA: begin
        proximo = OCIOSO;
      end
      default: begin
        proximo = OCIOSO;
      end
    endcase
  end

  always_comb begin
    amostra          = 1'b0;
    entrega          = (estado == ENTREGA);
    ocupado          = (estado != OCIOSO);
    erro_par_calc    = 1'b0;
    erro_quadro_calc = ~bit_parada;
    case (estado)
      INICIO:                 amostra = (timer == MEIO_BIT);
      DADOS, PARIDADE, PARADA: amostra = (timer == FIM_BIT);
      default:                amostra = 1'b0;
    endcase
    erro_par_calc = PARIDADE_IMPAR ? ~(^{deslocador, bit_paridade})
                                   :  (^{deslocador, bit_paridade});
  end

  // Timer restarts on every sample, so each later sample lands a full bit after the last one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer        <= '0;
      indice       <= '0;
      deslocador   <= '0;
      bit_paridade <= 1'b0;
      bit_parada   <= 1'b0;
    end else begin
      if ((estado == OCIOSO) || amostra) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end

      if (estado == INICIO) begin
        indice <= '0;
      end else if ((estado == DADOS) && amostra) begin
        indice <= indice + 3'd1;
      end

      if ((estado == DADOS) && amostra) begin
        deslocador[indice] <= rx_s;
      end
      if ((estado == PARIDADE) && amostra) begin
        bit_paridade <= rx_s;
      end
      if ((estado == PARADA) && amostra) begin
        bit_parada <= rx_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dados_q       <= '0;
      erro_par_q    <= 1'b0;
      erro_quadro_q <= 1'b0;
      valido_q      <= 1'b0;
      contador_q    <= '0;
    end else begin
      valido_q <= entrega;
      if (entrega) begin
        dados_q       <= deslocador;
        erro_par_q    <= erro_par_calc;
        erro_quadro_q <= erro_quadro_calc;
      end
      if (bus.limpar_contador) begin
        contador_q <= '0;
      end else if (entrega && (erro_par_calc || erro_quadro_calc) && (contador_q != '1)) begin
        contador_q <= contador_q + 1'b1;
      end
    end
  end

  assign bus.dados_saida    = dados_q;
  assign bus.erro_paridade  = erro_par_q;
  assign bus.erro_quadro    = erro_quadro_q;
  assign bus.valido         = valido_q;
  assign bus.ocupado        = ocupado;
  assign bus.contador_erros = contador_q;

endmodule
